write_reg_queue: RTL

Parametrised successor to the write-register destination mux. It selects the destination register of an issuing instruction using the same 2-bit selector encoding as before: rt, rd from instr[15:11], an alternate register, or $ra. Instead of driving the register file directly, it enqueues that destination into a DEPTH-entry in-order queue of pending writes, releases entries to write-back through a valid/ready handshake, and reports read-after-write hazards for two source registers against all in-flight destinations.

---
 rtl/write_reg_pkg.sv | 16 +
 rtl/write_reg_select.sv | 44 ++++
 rtl/write_reg_queue.sv | 100 ++++++++++
 3 files changed

// File: rtl/write_reg_pkg.sv
// Shared constants for the write-register destination path: selector
// encodings, the default link register and the rd field position.
package write_reg_pkg;

  typedef enum logic [1:0] {
    SEL_RT  = 2'b00,
    SEL_RD  = 2'b01,
    SEL_ALT = 2'b10,
    SEL_RA  = 2'b11
  } sel_e;

  localparam int unsigned DEFAULT_RA_ADDR = 31;
  localparam int unsigned RD_MSB          = 15;
  localparam int unsigned RD_LSB          = 11;

endpackage

// File: rtl/write_reg_select.sv
// Combinational destination-register decode: rt, rd (offset[15:11]),
// alternate register or the link register.
module write_reg_select
  import write_reg_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned RA_ADDR = DEFAULT_RA_ADDR
) (
  input  logic [1:0]        selector,
  input  logic [ADDR_W-1:0] rt,
  input  logic [15:0]       offset,
  input  logic [ADDR_W-1:0] alt_reg,
  output logic [ADDR_W-1:0] dest
);

  localparam int unsigned RD_W = RD_MSB - RD_LSB + 1;
  localparam logic [ADDR_W-1:0] RA = RA_ADDR[ADDR_W-1:0];

  logic [RD_W-1:0]   w_rd_field;
  logic [ADDR_W-1:0] w_rd;
  logic              w_unused;

  assign w_rd_field = offset[RD_MSB:RD_LSB];
  assign w_unused   = ^{offset[RD_LSB-1:0], w_rd_field};

  // Narrow address spaces keep the low bits of the rd slice; wide ones zero-extend.
  if (ADDR_W <= RD_W) begin : g_rd_narrow
    assign w_rd = w_rd_field[ADDR_W-1:0];
  end else begin : g_rd_wide
    assign w_rd = {{(ADDR_W - RD_W){1'b0}}, w_rd_field};
  end

  always_comb begin
    dest = rt;
    case (sel_e'(selector))
      SEL_RT:  dest = rt;
      SEL_RD:  dest = w_rd;
      SEL_ALT: dest = alt_reg;
      SEL_RA:  dest = RA;
      default: dest = rt;
    endcase
  end

endmodule

// File: rtl/write_reg_queue.sv
// In-order queue of pending register writes with a valid/ready write-back
// port, flush, and read-after-write hazard detection for two sources.
module write_reg_queue
  import write_reg_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned RA_ADDR = DEFAULT_RA_ADDR
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               selector,
  input  logic [ADDR_W-1:0]        rt,
  input  logic [15:0]              offset,
  input  logic [ADDR_W-1:0]        alt_reg,
  input  logic                     push_valid,
  output logic                     push_ready,
  output logic                     wb_valid,
  output logic [ADDR_W-1:0]        wb_reg,
  input  logic                     wb_ready,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        src_a,
  input  logic [ADDR_W-1:0]        src_b,
  output logic                     hazard_a,
  output logic                     hazard_b,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] r_entries [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [ADDR_W-1:0] w_dest;
  logic              w_push;
  logic              w_pop;
  logic [DEPTH-1:0]  w_valid;
  logic [DEPTH-1:0]  w_hit_a;
  logic [DEPTH-1:0]  w_hit_b;

  write_reg_select #(
    .ADDR_W  (ADDR_W),
    .RA_ADDR (RA_ADDR)
  ) u_select (
    .selector (selector),
    .rt       (rt),
    .offset   (offset),
    .alt_reg  (alt_reg),
    .dest     (w_dest)
  );

  assign push_ready = (r_count != FULL_CNT);
  assign wb_valid   = (r_count != '0);
  assign w_push     = push_valid && push_ready;
  assign w_pop      = wb_valid && wb_ready;
  assign wb_reg     = wb_valid ? r_entries[r_rd_ptr] : '0;
  assign count      = r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_entries[r_wr_ptr] <= w_dest;
        r_wr_ptr            <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // An entry is live when its distance from the head is below the count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    localparam logic [PTR_W-1:0] IDX = PTR_W'(gi);
    logic [PTR_W-1:0] w_dist;
    assign w_dist      = IDX - r_rd_ptr;
    assign w_valid[gi] = ({1'b0, w_dist} < r_count);
    assign w_hit_a[gi] = w_valid[gi] && (r_entries[gi] == src_a);
    assign w_hit_b[gi] = w_valid[gi] && (r_entries[gi] == src_b);
  end

  assign hazard_a = (src_a != '0) && (|w_hit_a);
  assign hazard_b = (src_b != '0) && (|w_hit_b);

endmodule
